// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage pipeline.
//
// Owns the program counter, presents it to the instruction memory
// (combinational read) and captures the returned instruction into the IF/ID
// register. Handles idle/exec sequencing, hazard stalls, taken-branch
// redirect with flush, and HALT detection.
//
// Ports:
//   clock          pipeline clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         run enable; 0 forces idle
//   start          begin execution (sampled only in idle)
//   stall          hold request from the hazard unit
//   branch_taken   redirect request from execute
//   branch_target  redirect address
//   i_datain       instruction returned for i_addr (same cycle)
//   i_addr         instruction memory address (= pc)
//   id_ir          IF/ID instruction register
//   id_pc          address of the instruction held in id_ir
//   halted         HALT fetched; fetch frozen
//   state          1'b0 = idle, 1'b1 = exec
//   fetch_count    instructions accepted into id_ir (bubbles excluded)
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = 8'h00,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 16'h0000,
    parameter logic [4:0]             HALT_OP     = 5'b00001
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic [INSTR_WIDTH-1:0] i_datain,
    output logic [PC_WIDTH-1:0]    i_addr,
    output logic [INSTR_WIDTH-1:0] id_ir,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic                   halted,
    output logic                   state,
    output logic [15:0]            fetch_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] id_ir_q, id_ir_d;
    logic [PC_WIDTH-1:0]    id_pc_q, id_pc_d;
    logic                   halted_q, halted_d;
    logic [15:0]            fetch_count_q, fetch_count_d;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        id_ir_d       = id_ir_q;
        id_pc_d       = id_pc_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;

        // Next-state decision: enable low always wins and lands in idle.
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE && start) begin
            state_d = ST_EXEC;
        end

        if (state_q == ST_IDLE || state_d == ST_IDLE) begin
            // Idle, and the edge that enters or leaves idle, parks the front
            // end at RESET_PC with a bubble; the first fetch happens one edge
            // after entering exec. fetch_count is a lifetime counter and holds.
            pc_d     = RESET_PC;
            id_ir_d  = NOP_INSTR;
            id_pc_d  = '0;
            halted_d = 1'b0;
        end else if (branch_taken) begin
            // Branch beats stall and any HALT fetched down the wrong path.
            pc_d     = branch_target;
            id_ir_d  = NOP_INSTR;
            halted_d = 1'b0;
        end else if (stall) begin
            // Everything holds (defaults).
        end else if (halted_q) begin
            id_ir_d = NOP_INSTR;
        end else begin
            id_ir_d       = i_datain;
            id_pc_d       = pc_q;
            fetch_count_d = fetch_count_q + 16'd1;
            if (i_datain[INSTR_WIDTH-1 -: 5] == HALT_OP) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_q + 1'b1;   // wraps modulo 2^PC_WIDTH
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            id_ir_q       <= NOP_INSTR;
            id_pc_q       <= '0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_ir_q       <= id_ir_d;
            id_pc_q       <= id_pc_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign i_addr      = pc_q;
    assign id_ir       = id_ir_q;
    assign id_pc       = id_pc_q;
    assign halted      = halted_q;
    assign state       = state_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed testbench for if_stage.
// A behavioural instruction memory answers i_addr combinationally. Each step
// drives inputs, advances one rising edge and checks outputs 1 ns later
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [15:0] i_datain;
    logic [7:0]  i_addr;
    logic [15:0] id_ir;
    logic [7:0]  id_pc;
    logic        halted;
    logic        state;
    logic [15:0] fetch_count;

    logic [15:0] mem [256];

    int checks   = 0;
    int failures = 0;

    if_stage dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .enable       (enable),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .i_datain     (i_datain),
        .i_addr       (i_addr),
        .id_ir        (id_ir),
        .id_pc        (id_pc),
        .halted       (halted),
        .state        (state),
        .fetch_count  (fetch_count)
    );

    always #5 clock = ~clock;

    assign i_datain = mem[i_addr];

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Checks the full observable state in one call.
    task automatic expect_all(input string tag, input logic st, input logic [7:0] pc,
                              input logic [15:0] ir, input logic [7:0] ipc,
                              input logic hlt, input logic [15:0] fc);
        check({tag, ".state"},  {31'd0, state},  {31'd0, st});
        check({tag, ".pc"},     {24'd0, i_addr}, {24'd0, pc});
        check({tag, ".id_ir"},  {16'd0, id_ir},  {16'd0, ir});
        check({tag, ".id_pc"},  {24'd0, id_pc},  {24'd0, ipc});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, hlt});
        check({tag, ".fcount"}, {16'd0, fetch_count}, {16'd0, fc});
    endtask

    initial begin
        // Default memory content: {8'h30, addr}, opcode 00110, never HALT.
        for (int a = 0; a < 256; a++) mem[a] = {8'h30, a[7:0]};
        mem[8'h00] = 16'h4f10;
        mem[8'h01] = 16'h81b6;
        mem[8'h4f] = 16'hc910;
        mem[8'h69] = 16'h0800;

        rst_n = 1'b0; enable = 1'b0; start = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 8'h00;
        #12;
        expect_all("reset", 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'd0);
        rst_n = 1'b1;

        // Start sequencing.
        enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        expect_all("start_e1", 1'b1, 8'h00, 16'h0000, 8'h00, 1'b0, 16'd0);
        tick();
        expect_all("start_e2", 1'b1, 8'h01, 16'h4f10, 8'h00, 1'b0, 16'd1);
        tick();
        expect_all("start_e3", 1'b1, 8'h02, 16'h81b6, 8'h01, 1'b0, 16'd2);
        tick(); tick(); tick();
        expect_all("run_pc5", 1'b1, 8'h05, 16'h3004, 8'h04, 1'b0, 16'd5);

        // Stall three cycles at pc = 5.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_all("stall", 1'b1, 8'h05, 16'h3004, 8'h04, 1'b0, 16'd5);
        end
        stall = 1'b0;
        tick();
        expect_all("stall_rel", 1'b1, 8'h06, 16'h3005, 8'h05, 1'b0, 16'd6);

        // Get to pc = 8'h52, then branch to 8'h4f.
        branch_taken = 1'b1; branch_target = 8'h52;
        tick();
        expect_all("br_to52", 1'b1, 8'h52, 16'h0000, 8'h05, 1'b0, 16'd6);
        branch_target = 8'h4f;
        tick();
        branch_taken = 1'b0;
        expect_all("br_4f", 1'b1, 8'h4f, 16'h0000, 8'h05, 1'b0, 16'd6);
        tick();
        expect_all("br_4f_fetch", 1'b1, 8'h50, 16'hc910, 8'h4f, 1'b0, 16'd7);
        tick(); tick();
        expect_all("run_pc52", 1'b1, 8'h52, 16'h3051, 8'h51, 1'b0, 16'd9);

        // Same branch with stall asserted together: branch wins.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h4f;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        expect_all("brstall_4f", 1'b1, 8'h4f, 16'h0000, 8'h51, 1'b0, 16'd9);
        tick();
        expect_all("brstall_fetch", 1'b1, 8'h50, 16'hc910, 8'h4f, 1'b0, 16'd10);

        // HALT at 8'h69.
        branch_taken = 1'b1; branch_target = 8'h69;
        tick();
        branch_taken = 1'b0;
        tick();
        expect_all("halt_fetch", 1'b1, 8'h69, 16'h0800, 8'h69, 1'b1, 16'd11);
        tick();
        expect_all("halt_hold1", 1'b1, 8'h69, 16'h0000, 8'h69, 1'b1, 16'd11);
        tick();
        expect_all("halt_hold2", 1'b1, 8'h69, 16'h0000, 8'h69, 1'b1, 16'd11);
        branch_taken = 1'b1; branch_target = 8'h10;
        tick();
        branch_taken = 1'b0;
        expect_all("halt_brk", 1'b1, 8'h10, 16'h0000, 8'h69, 1'b0, 16'd11);
        tick();
        expect_all("halt_brk_fetch", 1'b1, 8'h11, 16'h3010, 8'h10, 1'b0, 16'd12);

        // PC wrap at 8'hff.
        branch_taken = 1'b1; branch_target = 8'hff;
        tick();
        branch_taken = 1'b0;
        tick();
        expect_all("wrap", 1'b1, 8'h00, 16'h30ff, 8'hff, 1'b0, 16'd13);

        // Drop enable while halted: halted clears on entering idle.
        branch_taken = 1'b1; branch_target = 8'h69;
        tick();
        branch_taken = 1'b0;
        tick();
        expect_all("halt2", 1'b1, 8'h69, 16'h0800, 8'h69, 1'b1, 16'd14);
        enable = 1'b0; start = 1'b1;   // start alone must not keep exec
        tick();
        expect_all("disable", 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'd14);
        start = 1'b0;
        tick();
        expect_all("idle_hold", 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'd14);

        // Restart from RESET_PC.
        enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        expect_all("restart_e1", 1'b1, 8'h00, 16'h0000, 8'h00, 1'b0, 16'd14);
        tick();
        expect_all("restart_e2", 1'b1, 8'h01, 16'h4f10, 8'h00, 1'b0, 16'd15);
        tick();

        // Asynchronous reset mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        expect_all("async_rst", 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
